// File: rtl/rv32i_enc_pkg.sv
`default_nettype none
//==============================================================================
// Module   : rv32i_enc_pkg
// Purpose  : Symbolic RV32I op list, instruction formats, error codes, and the
//            opcode/funct constants used by the IMEM stream encoder.
// Revision : 1.0 - initial release
//==============================================================================
package rv32i_enc_pkg;

    typedef enum logic [5:0] {
        OP_ADD   = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2,  OP_SLT   = 6'd3,
        OP_SLTU  = 6'd4,  OP_XOR   = 6'd5,  OP_SRL   = 6'd6,  OP_SRA   = 6'd7,
        OP_OR    = 6'd8,  OP_AND   = 6'd9,
        OP_ADDI  = 6'd10, OP_SLTI  = 6'd11, OP_SLTIU = 6'd12, OP_XORI  = 6'd13,
        OP_ORI   = 6'd14, OP_ANDI  = 6'd15, OP_SLLI  = 6'd16, OP_SRLI  = 6'd17,
        OP_SRAI  = 6'd18,
        OP_LB    = 6'd19, OP_LH    = 6'd20, OP_LW    = 6'd21, OP_LBU   = 6'd22,
        OP_LHU   = 6'd23,
        OP_SB    = 6'd24, OP_SH    = 6'd25, OP_SW    = 6'd26,
        OP_BEQ   = 6'd27, OP_BNE   = 6'd28, OP_BLT   = 6'd29, OP_BGE   = 6'd30,
        OP_BLTU  = 6'd31, OP_BGEU  = 6'd32,
        OP_LUI   = 6'd33, OP_AUIPC = 6'd34, OP_JAL   = 6'd35, OP_JALR  = 6'd36
    } rv32i_op_t;

    // FMT_SH is I-type with the shamt taken from the rs2 field
    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } rv32i_fmt_t;

    typedef struct packed {
        rv32i_fmt_t  fmt;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } rv32i_dec_t;

    localparam logic [1:0] c_ERR_ILLEGAL = 2'd0;
    localparam logic [1:0] c_ERR_RANGE   = 2'd1;
    localparam logic [1:0] c_ERR_ALIGN   = 2'd2;
    localparam logic [1:0] c_ERR_SHAMT   = 2'd3;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_F7_BASE    = 7'b0000000;
    localparam logic [6:0] c_F7_ALT     = 7'b0100000;

    // Map a symbolic op to its format, major opcode and funct fields
    function automatic rv32i_dec_t rv32i_decode(input logic [5:0] op);
        rv32i_dec_t dec;
        dec = '{FMT_BAD, 7'd0, 3'd0, c_F7_BASE};
        case (op)
            OP_ADD:   dec = '{FMT_R,  c_OPC_OP,     3'd0, c_F7_BASE};
            OP_SUB:   dec = '{FMT_R,  c_OPC_OP,     3'd0, c_F7_ALT};
            OP_SLL:   dec = '{FMT_R,  c_OPC_OP,     3'd1, c_F7_BASE};
            OP_SLT:   dec = '{FMT_R,  c_OPC_OP,     3'd2, c_F7_BASE};
            OP_SLTU:  dec = '{FMT_R,  c_OPC_OP,     3'd3, c_F7_BASE};
            OP_XOR:   dec = '{FMT_R,  c_OPC_OP,     3'd4, c_F7_BASE};
            OP_SRL:   dec = '{FMT_R,  c_OPC_OP,     3'd5, c_F7_BASE};
            OP_SRA:   dec = '{FMT_R,  c_OPC_OP,     3'd5, c_F7_ALT};
            OP_OR:    dec = '{FMT_R,  c_OPC_OP,     3'd6, c_F7_BASE};
            OP_AND:   dec = '{FMT_R,  c_OPC_OP,     3'd7, c_F7_BASE};
            OP_ADDI:  dec = '{FMT_I,  c_OPC_OPIMM,  3'd0, c_F7_BASE};
            OP_SLTI:  dec = '{FMT_I,  c_OPC_OPIMM,  3'd2, c_F7_BASE};
            OP_SLTIU: dec = '{FMT_I,  c_OPC_OPIMM,  3'd3, c_F7_BASE};
            OP_XORI:  dec = '{FMT_I,  c_OPC_OPIMM,  3'd4, c_F7_BASE};
            OP_ORI:   dec = '{FMT_I,  c_OPC_OPIMM,  3'd6, c_F7_BASE};
            OP_ANDI:  dec = '{FMT_I,  c_OPC_OPIMM,  3'd7, c_F7_BASE};
            OP_SLLI:  dec = '{FMT_SH, c_OPC_OPIMM,  3'd1, c_F7_BASE};
            OP_SRLI:  dec = '{FMT_SH, c_OPC_OPIMM,  3'd5, c_F7_BASE};
            OP_SRAI:  dec = '{FMT_SH, c_OPC_OPIMM,  3'd5, c_F7_ALT};
            OP_LB:    dec = '{FMT_I,  c_OPC_LOAD,   3'd0, c_F7_BASE};
            OP_LH:    dec = '{FMT_I,  c_OPC_LOAD,   3'd1, c_F7_BASE};
            OP_LW:    dec = '{FMT_I,  c_OPC_LOAD,   3'd2, c_F7_BASE};
            OP_LBU:   dec = '{FMT_I,  c_OPC_LOAD,   3'd4, c_F7_BASE};
            OP_LHU:   dec = '{FMT_I,  c_OPC_LOAD,   3'd5, c_F7_BASE};
            OP_SB:    dec = '{FMT_S,  c_OPC_STORE,  3'd0, c_F7_BASE};
            OP_SH:    dec = '{FMT_S,  c_OPC_STORE,  3'd1, c_F7_BASE};
            OP_SW:    dec = '{FMT_S,  c_OPC_STORE,  3'd2, c_F7_BASE};
            OP_BEQ:   dec = '{FMT_B,  c_OPC_BRANCH, 3'd0, c_F7_BASE};
            OP_BNE:   dec = '{FMT_B,  c_OPC_BRANCH, 3'd1, c_F7_BASE};
            OP_BLT:   dec = '{FMT_B,  c_OPC_BRANCH, 3'd4, c_F7_BASE};
            OP_BGE:   dec = '{FMT_B,  c_OPC_BRANCH, 3'd5, c_F7_BASE};
            OP_BLTU:  dec = '{FMT_B,  c_OPC_BRANCH, 3'd6, c_F7_BASE};
            OP_BGEU:  dec = '{FMT_B,  c_OPC_BRANCH, 3'd7, c_F7_BASE};
            OP_LUI:   dec = '{FMT_U,  c_OPC_LUI,    3'd0, c_F7_BASE};
            OP_AUIPC: dec = '{FMT_U,  c_OPC_AUIPC,  3'd0, c_F7_BASE};
            OP_JAL:   dec = '{FMT_J,  c_OPC_JAL,    3'd0, c_F7_BASE};
            OP_JALR:  dec = '{FMT_I,  c_OPC_JALR,   3'd0, c_F7_BASE};
            default:  dec = '{FMT_BAD, 7'd0, 3'd0, c_F7_BASE};
        endcase
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_instr_encode.sv
`default_nettype none
//==============================================================================
// Module   : rv32i_instr_encode
// Purpose  : Combinational encoder: symbolic op + fields -> 32-bit RV32I word,
//            with immediate range / alignment / legality checking.
// Revision : 1.0 - initial release
//==============================================================================
module rv32i_instr_encode
    import rv32i_enc_pkg::*;
(
    input  logic [5:0]  i_op,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_word,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    rv32i_dec_t w_dec;
    logic       w_fit12;
    logic       w_fit13;
    logic       w_fit21;
    logic       w_fitu;

    // Decode, check the immediate for the selected format, and assemble the word
    always_comb begin
        w_dec      = rv32i_decode(i_op);
        // A value fits N signed bits when bits [31:N-1] are all sign copies
        w_fit12    = (&i_imm[31:11]) | ~(|i_imm[31:11]);
        w_fit13    = (&i_imm[31:12]) | ~(|i_imm[31:12]);
        w_fit21    = (&i_imm[31:20]) | ~(|i_imm[31:20]);
        w_fitu     = ~(|i_imm[31:20]);
        o_word     = '0;
        o_err      = 1'b0;
        o_err_code = c_ERR_ILLEGAL;
        case (w_dec.fmt)
            FMT_R, FMT_SH: begin
                o_word = {w_dec.f7, i_rs2, i_rs1, w_dec.f3, i_rd, w_dec.opc};
            end
            FMT_I: begin
                o_word = {i_imm[11:0], i_rs1, w_dec.f3, i_rd, w_dec.opc};
                if (!w_fit12) begin
                    o_err = 1'b1; o_err_code = c_ERR_RANGE;
                end
            end
            FMT_S: begin
                o_word = {i_imm[11:5], i_rs2, i_rs1, w_dec.f3, i_imm[4:0], w_dec.opc};
                if (!w_fit12) begin
                    o_err = 1'b1; o_err_code = c_ERR_RANGE;
                end
            end
            FMT_B: begin
                o_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_dec.f3,
                          i_imm[4:1], i_imm[11], w_dec.opc};
                if (!w_fit13) begin
                    o_err = 1'b1; o_err_code = c_ERR_RANGE;
                end else if (i_imm[0]) begin
                    o_err = 1'b1; o_err_code = c_ERR_ALIGN;
                end
            end
            FMT_U: begin
                o_word = {i_imm[19:0], i_rd, w_dec.opc};
                if (!w_fitu) begin
                    o_err = 1'b1; o_err_code = c_ERR_RANGE;
                end
            end
            FMT_J: begin
                o_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_dec.opc};
                if (!w_fit21) begin
                    o_err = 1'b1; o_err_code = c_ERR_RANGE;
                end else if (i_imm[0]) begin
                    o_err = 1'b1; o_err_code = c_ERR_ALIGN;
                end
            end
            default: begin
                o_err = 1'b1; o_err_code = c_ERR_ILLEGAL;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_imem_stream_encoder.sv
`default_nettype none
//==============================================================================
// Module   : rv32i_imem_stream_encoder
// Purpose  : Accepts symbolic RV32I instructions over valid/ready, writes
//            NOP_PAD padding words then the encoded word into IMEM through an
//            auto-incrementing word-address write port.
// Revision : 1.0 - initial release
//==============================================================================
module rv32i_imem_stream_encoder
    import rv32i_enc_pkg::*;
#(
    parameter int          NOP_PAD    = 3,
    parameter logic [31:0] PAD_WORD   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Clear,
    input  logic              i_Valid,
    output logic              o_Ready,
    input  logic [5:0]        i_Op,
    input  logic [4:0]        i_Rd,
    input  logic [4:0]        i_Rs1,
    input  logic [4:0]        i_Rs2,
    input  logic [31:0]       i_Imm,
    output logic              o_Mem_We,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic [31:0]       o_Mem_Wdata,
    output logic              o_Full,
    output logic              o_Err,
    output logic [1:0]        o_Err_Code,
    output logic [ADDR_W:0]   o_Count
);

    localparam logic [1:0]  c_ST_IDLE  = 2'd0;
    localparam logic [1:0]  c_ST_PAD   = 2'd1;
    localparam logic [1:0]  c_ST_EMIT  = 2'd2;
    localparam int          c_PAD_LAST = (NOP_PAD > 0) ? NOP_PAD - 1 : 0;
    localparam logic [31:0] c_NEED     = 32'(NOP_PAD + 1);
    localparam logic [31:0] c_DEPTH    = 32'(IMEM_DEPTH);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [3:0]      r_pad_cnt;
    logic [3:0]      w_pad_cnt_next;
    // One bit wider than the port address so a completely filled IMEM is representable
    logic [ADDR_W:0] r_addr;
    logic [ADDR_W:0] w_addr_next;
    logic [31:0]     r_word;
    logic            r_err;
    logic [1:0]      r_err_code;
    logic            r_full;
    logic            w_we;
    logic            w_full_next;
    logic            w_ready;
    logic            w_accept;
    logic [31:0]     w_enc_word;
    logic            w_enc_err;
    logic [1:0]      w_enc_code;

    rv32i_instr_encode u_encode (
        .i_op       (i_Op),
        .i_rd       (i_Rd),
        .i_rs1      (i_Rs1),
        .i_rs2      (i_Rs2),
        .i_imm      (i_Imm),
        .o_word     (w_enc_word),
        .o_err      (w_enc_err),
        .o_err_code (w_enc_code)
    );

    // Write strobe, address/room bookkeeping, handshake and next-state selection
    always_comb begin
        w_we        = (r_state == c_ST_PAD) || (r_state == c_ST_EMIT);
        w_addr_next = r_addr + {{ADDR_W{1'b0}}, w_we};
        // Room is judged after this cycle's write so EMIT can accept without a bubble
        w_full_next = (32'(w_addr_next) + c_NEED) > c_DEPTH;
        w_ready     = ((r_state == c_ST_IDLE) || (r_state == c_ST_EMIT)) && !w_full_next;
        w_accept    = i_Valid && w_ready;

        w_state_next   = r_state;
        w_pad_cnt_next = r_pad_cnt;
        case (r_state)
            c_ST_PAD: begin
                if (r_pad_cnt == 4'd0) begin
                    w_state_next = c_ST_EMIT;
                end else begin
                    w_pad_cnt_next = r_pad_cnt - 4'd1;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase

        // A rejected item is consumed but leaves the FSM heading to IDLE
        if (w_accept && !w_enc_err) begin
            if (NOP_PAD > 0) begin
                w_state_next   = c_ST_PAD;
                w_pad_cnt_next = 4'(c_PAD_LAST);
            end else begin
                w_state_next = c_ST_EMIT;
            end
        end
    end

    // State, counters and registered status; reset and clear restart identically
    always_ff @(posedge i_Clk) begin
        if (i_Reset || i_Clear) begin
            r_state    <= c_ST_IDLE;
            r_pad_cnt  <= 4'd0;
            r_addr     <= '0;
            r_word     <= '0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_full     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pad_cnt <= w_pad_cnt_next;
            r_addr    <= w_addr_next;
            r_full    <= w_full_next;
            r_err     <= w_accept && w_enc_err;
            if (w_accept && w_enc_err) begin
                r_err_code <= w_enc_code;
            end
            if (w_accept && !w_enc_err) begin
                r_word <= w_enc_word;
            end
        end
    end

    // Write data follows the state: padding, the held instruction, or zero when idle
    always_comb begin
        o_Mem_Wdata = '0;
        if (r_state == c_ST_EMIT) begin
            o_Mem_Wdata = r_word;
        end else if (r_state == c_ST_PAD) begin
            o_Mem_Wdata = PAD_WORD;
        end
    end

    assign o_Ready    = w_ready;
    assign o_Mem_We   = w_we;
    assign o_Mem_Addr = r_addr[ADDR_W-1:0];
    assign o_Full     = r_full;
    assign o_Err      = r_err;
    assign o_Err_Code = r_err_code;
    assign o_Count    = r_addr;

endmodule
`default_nettype wire
